// File: rtl/instr_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : instr_arb_pkg
//  Description : Shared types and helpers for the instruction-memory arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package instr_arb_pkg;

  // Which requester owns the response returned in the current cycle
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CORE = 2'd1,
    OWN_BUS  = 2'd2
  } owner_e;

  // Boot ROM region is selected by the address MSB; callers zero-extend
  // their address and pass its real width so one helper serves any width.
  function automatic logic is_boot_addr(input logic [63:0] addr,
                                        input int unsigned aw);
    return addr[aw-1];
  endfunction

endpackage : instr_arb_pkg
`default_nettype wire

// File: rtl/instr_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : instr_mem_arbiter_if
//  Description : Core fetch, bus loader/debug and memory-side signals of the
//                instruction-memory arbiter, grouped as one interface.
//  Revision    : 1.0 - initial release
// ============================================================================
interface instr_mem_arbiter_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
);
  // Core fetch port
  logic                    core_req_i;
  logic [ADDR_WIDTH-1:0]   core_addr_i;
  logic                    core_gnt_o;
  logic                    core_rvalid_o;
  logic [DATA_WIDTH-1:0]   core_rdata_o;
  // Bus loader/debug port
  logic                    bus_req_i;
  logic                    bus_we_i;
  logic [ADDR_WIDTH-1:0]   bus_addr_i;
  logic [DATA_WIDTH-1:0]   bus_wdata_i;
  logic [DATA_WIDTH/8-1:0] bus_be_i;
  logic                    bus_gnt_o;
  logic                    bus_rvalid_o;
  logic [DATA_WIDTH-1:0]   bus_rdata_o;
  // Memory side
  logic                    mem_en_o;
  logic                    mem_we_o;
  logic [ADDR_WIDTH-1:0]   mem_addr_o;
  logic [DATA_WIDTH-1:0]   mem_wdata_o;
  logic [DATA_WIDTH/8-1:0] mem_be_o;
  logic [DATA_WIDTH-1:0]   mem_rdata_i;

  // Arbiter view
  modport slave (
    input  core_req_i, core_addr_i,
    output core_gnt_o, core_rvalid_o, core_rdata_o,
    input  bus_req_i, bus_we_i, bus_addr_i, bus_wdata_i, bus_be_i,
    output bus_gnt_o, bus_rvalid_o, bus_rdata_o,
    output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
    input  mem_rdata_i
  );

  // Environment view: requesters plus the memory
  modport master (
    output core_req_i, core_addr_i,
    input  core_gnt_o, core_rvalid_o, core_rdata_o,
    output bus_req_i, bus_we_i, bus_addr_i, bus_wdata_i, bus_be_i,
    input  bus_gnt_o, bus_rvalid_o, bus_rdata_o,
    input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
    output mem_rdata_i
  );

endinterface : instr_mem_arbiter_if
`default_nettype wire

// File: rtl/instr_mem_arbiter_starve_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : instr_arb_starve_cnt
//  Description : Saturating count of consecutive contested cycles lost by
//                the bus port. Clear has priority over increment.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_arb_starve_cnt #(
  parameter int MAX_STARVE = 4,
  parameter int CNT_W      = $clog2(MAX_STARVE + 1)
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             i_inc,
  input  wire logic             i_clr,
  output logic      [CNT_W-1:0] o_cnt,
  output logic                  o_sat
);

  localparam logic [CNT_W-1:0] c_max = CNT_W'(MAX_STARVE);

  logic [CNT_W-1:0] r_cnt;

  // Count lost contested cycles, holding at the bound until cleared
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != c_max)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;
  assign o_sat = (r_cnt == c_max);

endmodule : instr_arb_starve_cnt
`default_nettype wire

// File: rtl/instr_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : instr_mem_arbiter
//  Description : Shares the single-port instruction RAM/boot ROM between the
//                core fetch port (fixed priority) and the bus port, with a
//                starvation bound for the bus and tagged response routing.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_mem_arbiter
  import instr_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_STARVE = 4
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  instr_mem_arbiter_if.slave ifc
);

  localparam int CNT_W = $clog2(MAX_STARVE + 1);

  logic             w_both;
  logic             w_sat;
  logic             w_bus_win;
  logic             w_core_win;
  logic             w_bus_boot_wr;
  logic             w_inc;
  logic             w_clr;
  logic [CNT_W-1:0] w_starve_cnt;
  owner_e           w_owner_nxt;

  owner_e           r_owner;
  logic             r_suppress;

  // Arbitration: core has priority unless the bus has hit its starvation bound
  always_comb begin
    w_both        = ifc.core_req_i & ifc.bus_req_i;
    w_bus_win     = ifc.bus_req_i & (~ifc.core_req_i | w_sat);
    w_core_win    = ifc.core_req_i & ~w_bus_win;
    w_bus_boot_wr = ifc.bus_we_i & is_boot_addr(64'(ifc.bus_addr_i), ADDR_WIDTH);
    w_inc         = w_both & w_core_win;
    w_clr         = w_bus_win | ~ifc.bus_req_i;
  end

  instr_arb_starve_cnt #(
    .MAX_STARVE (MAX_STARVE),
    .CNT_W      (CNT_W)
  ) u_starve (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (w_inc),
    .i_clr (w_clr),
    .o_cnt (w_starve_cnt),
    .o_sat (w_sat)
  );

  // Memory drive follows the winner; ROM writes are granted but never reach memory
  always_comb begin
    ifc.core_gnt_o  = w_core_win;
    ifc.bus_gnt_o   = w_bus_win;
    ifc.mem_en_o    = w_core_win | (w_bus_win & ~w_bus_boot_wr);
    ifc.mem_we_o    = w_bus_win & ifc.bus_we_i & ~w_bus_boot_wr;
    ifc.mem_addr_o  = w_bus_win ? ifc.bus_addr_i : ifc.core_addr_i;
    ifc.mem_wdata_o = w_bus_win ? ifc.bus_wdata_i : '0;
    ifc.mem_be_o    = w_bus_win ? ifc.bus_be_i : '1;
  end

  // Tag for the response that returns one cycle after the grant
  always_comb begin
    w_owner_nxt = OWN_NONE;
    if (w_bus_win) begin
      w_owner_nxt = OWN_BUS;
    end else if (w_core_win) begin
      w_owner_nxt = OWN_CORE;
    end
  end

  // Register response ownership; reset drops any in-flight response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner    <= OWN_NONE;
      r_suppress <= 1'b0;
    end else begin
      r_owner    <= w_owner_nxt;
      r_suppress <= w_bus_win & w_bus_boot_wr;
    end
  end

  // Route memory data back to the owning requester
  always_comb begin
    ifc.core_rvalid_o = (r_owner == OWN_CORE);
    ifc.bus_rvalid_o  = (r_owner == OWN_BUS);
    ifc.core_rdata_o  = ifc.mem_rdata_i;
    ifc.bus_rdata_o   = r_suppress ? '0 : ifc.mem_rdata_i;
  end

  // Counter value is observable only through its saturation flag here
  logic w_unused;
  assign w_unused = ^w_starve_cnt;

endmodule : instr_mem_arbiter
`default_nettype wire

// File: tb/tb_instr_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_mem_arbiter
//  Description : Directed self-checking bench for instr_mem_arbiter with a
//                one-cycle-latency RAM/ROM model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_mem_arbiter;

  logic clk;
  logic rst_n;
  int   n_assert;
  int   n_fail;

  logic [31:0] ram [0:255];

  instr_mem_arbiter_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) ifc ();

  instr_mem_arbiter #(
    .ADDR_WIDTH (16),
    .DATA_WIDTH (32),
    .MAX_STARVE (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ifc   (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM at addr[15]=0 (initial word 0xA5000000+index), ROM at addr[15]=1
  // (word 0xB0000000+index); index is addr[9:2]
  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 32'hA500_0000 + i;
  end

  always @(posedge clk) begin
    if (ifc.mem_en_o) begin
      if (ifc.mem_addr_o[15]) begin
        ifc.mem_rdata_i <= 32'hB000_0000 + {24'h0, ifc.mem_addr_o[9:2]};
      end else begin
        ifc.mem_rdata_i <= ram[ifc.mem_addr_o[9:2]];
        if (ifc.mem_we_o) begin
          for (int b = 0; b < 4; b++)
            if (ifc.mem_be_o[b]) ram[ifc.mem_addr_o[9:2]][8*b +: 8] <= ifc.mem_wdata_o[8*b +: 8];
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle();
    ifc.core_req_i  = 1'b0;
    ifc.core_addr_i = '0;
    ifc.bus_req_i   = 1'b0;
    ifc.bus_we_i    = 1'b0;
    ifc.bus_addr_i  = '0;
    ifc.bus_wdata_i = '0;
    ifc.bus_be_i    = '0;
  endtask

  task automatic bus_drive(input logic we, input logic [15:0] a, input logic [31:0] d);
    ifc.bus_req_i   = 1'b1;
    ifc.bus_we_i    = we;
    ifc.bus_addr_i  = a;
    ifc.bus_wdata_i = d;
    ifc.bus_be_i    = 4'hF;
  endtask

  logic exp_bus;
  logic prev_bus;

  initial begin
    n_assert = 0;
    n_fail   = 0;
    ifc.mem_rdata_i = '0;
    idle();
    rst_n = 1'b0;

    // Reset state
    tick(); #1;
    chk("rst_core_rvalid", ifc.core_rvalid_o, 0);
    chk("rst_bus_rvalid",  ifc.bus_rvalid_o,  0);
    chk("rst_core_gnt",    ifc.core_gnt_o,    0);
    chk("rst_bus_gnt",     ifc.bus_gnt_o,     0);
    chk("rst_mem_en",      ifc.mem_en_o,      0);
    tick(); rst_n = 1'b1;
    tick(); #1;
    chk("idle_mem_en", ifc.mem_en_o, 0);
    chk("idle_mem_we", ifc.mem_we_o, 0);
    chk("idle_rvalid", ifc.core_rvalid_o, 0);

    // Core-only fetch
    ifc.core_req_i = 1'b1; ifc.core_addr_i = 16'h0100; #1;
    chk("core_gnt",      ifc.core_gnt_o, 1);
    chk("core_bus_gnt",  ifc.bus_gnt_o,  0);
    chk("core_mem_en",   ifc.mem_en_o,   1);
    chk("core_mem_we",   ifc.mem_we_o,   0);
    chk("core_mem_addr", ifc.mem_addr_o, 32'h0100);
    tick(); idle(); #1;
    chk("core_rvalid",   ifc.core_rvalid_o, 1);
    chk("core_rdata",    ifc.core_rdata_o,  32'hA500_0040);
    chk("core_no_bus_rv", ifc.bus_rvalid_o, 0);

    // Bus write then read of 0x0040
    tick(); bus_drive(1'b1, 16'h0040, 32'hDEAD_BEEF); #1;
    chk("bw_gnt",    ifc.bus_gnt_o, 1);
    chk("bw_mem_en", ifc.mem_en_o,  1);
    chk("bw_mem_we", ifc.mem_we_o,  1);
    chk("bw_wdata",  ifc.mem_wdata_o, 32'hDEAD_BEEF);
    tick(); bus_drive(1'b0, 16'h0040, 32'h0); #1;
    chk("br_gnt",     ifc.bus_gnt_o,    1);
    chk("bw_rvalid",  ifc.bus_rvalid_o, 1);
    chk("br_mem_we",  ifc.mem_we_o,     0);
    tick(); idle(); #1;
    chk("br_rvalid",  ifc.bus_rvalid_o, 1);
    chk("br_rdata",   ifc.bus_rdata_o,  32'hDEAD_BEEF);
    tick(); #1;
    chk("br_rvalid_off", ifc.bus_rvalid_o, 0);

    // Contention: grants core x4, bus, core x4, bus
    ifc.core_req_i = 1'b1; ifc.core_addr_i = 16'h0100;
    bus_drive(1'b0, 16'h0000, 32'h0);
    prev_bus = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) tick();
      #1;
      exp_bus = (i == 4) || (i == 9);
      chk($sformatf("cont%0d_bus_gnt", i),  ifc.bus_gnt_o,  exp_bus);
      chk($sformatf("cont%0d_core_gnt", i), ifc.core_gnt_o, !exp_bus);
      if (i > 0) begin
        chk($sformatf("cont%0d_bus_rv", i),  ifc.bus_rvalid_o,  prev_bus);
        chk($sformatf("cont%0d_core_rv", i), ifc.core_rvalid_o, !prev_bus);
      end
      prev_bus = exp_bus;
    end
    tick(); idle(); #1;
    chk("cont_end_bus_rv",    ifc.bus_rvalid_o, 1);
    chk("cont_end_bus_rdata", ifc.bus_rdata_o,  32'hA500_0000);

    // Boot region write (suppressed) then read
    tick(); bus_drive(1'b1, 16'h8004, 32'h1234_5678); #1;
    chk("boot_w_gnt",    ifc.bus_gnt_o, 1);
    chk("boot_w_mem_en", ifc.mem_en_o,  0);
    chk("boot_w_mem_we", ifc.mem_we_o,  0);
    tick(); bus_drive(1'b0, 16'h8004, 32'h0); #1;
    chk("boot_w_rvalid", ifc.bus_rvalid_o, 1);
    chk("boot_w_rdata",  ifc.bus_rdata_o,  32'h0);
    chk("boot_r_mem_en", ifc.mem_en_o,     1);
    tick(); idle(); #1;
    chk("boot_r_rvalid", ifc.bus_rvalid_o, 1);
    chk("boot_r_rdata",  ifc.bus_rdata_o,  32'hB000_0001);

    // Interleaved ownership: core at N, bus at N+1
    tick(); ifc.core_req_i = 1'b1; ifc.core_addr_i = 16'h0100; #1;
    chk("il_core_gnt", ifc.core_gnt_o, 1);
    tick(); idle(); bus_drive(1'b0, 16'h0040, 32'h0); #1;
    chk("il_bus_gnt",      ifc.bus_gnt_o,     1);
    chk("il_n1_core_rv",   ifc.core_rvalid_o, 1);
    chk("il_n1_bus_rv",    ifc.bus_rvalid_o,  0);
    chk("il_n1_core_data", ifc.core_rdata_o,  32'hA500_0040);
    tick(); idle(); #1;
    chk("il_n2_core_rv",   ifc.core_rvalid_o, 0);
    chk("il_n2_bus_rv",    ifc.bus_rvalid_o,  1);
    chk("il_n2_bus_data",  ifc.bus_rdata_o,   32'hDEAD_BEEF);
    tick(); #1;
    chk("il_n3_bus_rv",    ifc.bus_rvalid_o,  0);

    // Reset in the cycle after a grant drops the response
    tick(); ifc.core_req_i = 1'b1; ifc.core_addr_i = 16'h0100; #1;
    chk("rr_gnt", ifc.core_gnt_o, 1);
    tick(); idle(); rst_n = 1'b0; #1;
    chk("rr_core_rv_in_rst", ifc.core_rvalid_o, 0);
    chk("rr_bus_rv_in_rst",  ifc.bus_rvalid_o,  0);
    tick(); rst_n = 1'b1; #1;
    chk("rr_core_rv_rel", ifc.core_rvalid_o, 0);
    tick(); #1;
    chk("rr_core_rv_after", ifc.core_rvalid_o, 0);
    chk("rr_bus_rv_after",  ifc.bus_rvalid_o,  0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_instr_mem_arbiter
`default_nettype wire

// File: doc/instr_mem_arbiter.md
# instr_mem_arbiter

Two-port arbiter that shares the single-port instruction memory (the instruction RAM plus boot ROM wrapper, one-cycle read latency) between the core instruction-fetch port and the bus-side loader/debug port. Core fetch has fixed priority. A starvation counter guarantees the bus port a slot after a bounded number of contested cycles. The block tags every granted access and returns the response, with rvalid, to the requester that owns it.

## Interface
- ADDR_WIDTH, 16, byte address width; MSB set selects the boot ROM region
- DATA_WIDTH, 32, data width
- MAX_STARVE, 4, maximum consecutive contested cycles the bus port loses before it is forced to win (≥1)

- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- core_req_i  in  1  core fetch request (read only)
- core_addr_i  in  ADDR_WIDTH  core fetch address
- core_gnt_o  out  1  core request accepted this cycle
- core_rvalid_o  out  1  core read data valid
- core_rdata_o  out  DATA_WIDTH  core read data
- bus_req_i  in  1  bus request
- bus_we_i  in  1  bus write enable
- bus_addr_i  in  ADDR_WIDTH  bus address
- bus_wdata_i  in  DATA_WIDTH  bus write data
- bus_be_i  in  DATA_WIDTH/8  bus byte enables
- bus_gnt_o  out  1  bus request accepted this cycle
- bus_rvalid_o  out  1  bus response valid (reads and writes)
- bus_rdata_o  out  DATA_WIDTH  bus read data
- mem_en_o, mem_we_o  out  1  memory enable, write enable
- mem_addr_o  out  ADDR_WIDTH  memory address
- mem_wdata_o  out  DATA_WIDTH  memory write data
- mem_be_o  out  DATA_WIDTH/8  memory byte enables
- mem_rdata_i  in  DATA_WIDTH  memory read data, one cycle after mem_en_o

## Operation
- Grant is combinational, issued in the same cycle as the request. At most one gnt is high per cycle. Request side: a requester holds req and its address/data stable until gnt.
- Arbitration:
  - Only one request: that request wins.
  - Both requests: core wins, unless starve_q == MAX_STARVE, in which case bus wins.
- Starvation counter starve_q, width $clog2(MAX_STARVE+1):
  - Increments on each cycle where both requests are high and core is granted.
  - Clears to 0 when bus is granted or bus_req_i is low.
  - Saturates at MAX_STARVE.
- Memory drive: mem_* carry the winner's fields; mem_we_o is 0 for core.
- Bus write to the boot region (bus_addr_i[ADDR_WIDTH-1]=1):
  - Granted, but mem_en_o=0 and mem_we_o=0 (ROM is not writable).
  - Still receives bus_rvalid_o.
- Bus read to the boot region is forwarded normally.
- Response tracking: owner_q ∈ {OWN_NONE, OWN_CORE, OWN_BUS} and suppress_q are registered at each grant.
  - core_rvalid_o = (owner_q==OWN_CORE).
  - bus_rvalid_o = (owner_q==OWN_BUS).
  - core_rdata_o = mem_rdata_i.
  - bus_rdata_o = suppress_q ? 0 : mem_rdata_i. Write responses return mem_rdata_i, content don't-care.
- Requests may be accepted back-to-back every cycle. A response and a new grant to either port can occur in the same cycle.

## Timing
- Reset values: owner_q=OWN_NONE, suppress_q=0, starve_q=0. Hence core_rvalid_o=bus_rvalid_o=0.
- Combinational outputs with no request pending: gnt=0, mem_en_o=0, mem_we_o=0.
- Latency: gnt in cycle N → rvalid in cycle N+1, exactly. There is no backpressure on responses.
- Reset asserted mid-transaction: the pending response is dropped and no rvalid is issued after reset release.
- Starvation bound: with both requests held continuously, bus is granted within MAX_STARVE+1 cycles.

## Structure
- Package instr_arb_pkg holds:
  - the owner enum type (OWN_NONE, OWN_CORE, OWN_BUS);
  - a helper function is_boot_addr(addr) that tests the region MSB.
- Sub-module instr_arb_starve_cnt: saturating counter with inc/clr/sat outputs, parameterised on MAX_STARVE.
- Everything else is flat in instr_mem_arbiter.

## Test plan
- Core-only fetch: core_req_i=1, addr 0x0100 → core_gnt_o=1 and mem_en_o=1, mem_addr_o=0x0100 the same cycle. Next cycle core_rvalid_o=1 with core_rdata_o equal to the memory model word.
- Bus write then read: write 0xDEADBEEF, be=0xF to 0x0040, then read 0x0040 → two grants on consecutive cycles, bus_rvalid_o on both following cycles, second response returns 0xDEADBEEF.
- Contention, MAX_STARVE=4, both requests held:
  - Grants follow core×4, bus, core×4, bus.
  - starve_q clears after each bus grant.
  - No cycle has two gnts.
- Boot region write: bus write to 0x8004 → bus_gnt_o=1, mem_en_o=0, mem_we_o=0; next cycle bus_rvalid_o=1, bus_rdata_o=0. Boot region read of 0x8004 returns the ROM word.
- Interleaved ownership: core grant in cycle N, bus grant in N+1 → core_rvalid_o in N+1 only, bus_rvalid_o in N+2 only, each carrying its own data.
- Reset in the cycle after a grant → rvalid outputs 0 immediately and stay 0 after release until a new grant.
